clk_div_multi: RTL and testbench

Multi-channel programmable clock/tick divider, the parametrised successor to the fixed 500 Hz debug divider. Each of `N_CH` channels produces a 50 % duty square wave `clk_out` and a one-cycle `tick` strobe from the system clock. Each channel's half-period is reloaded at runtime through a valid/ready config port. Reloads take effect only on period boundaries, so outputs never glitch. The block sits in the debug/tooling layer and drives LED blinkers, display-scan strobes and logic-analyser markers.

---
 rtl/clk_div_pkg.sv | 23 ++
 rtl/clk_div_ch.sv | 92 +++++++++
 rtl/clk_div_multi.sv | 66 ++++++
 tb/tb_clk_div_multi.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, types and helpers
// for the multi-channel clock/tick divider.
package clk_div_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int unsigned DEFAULT_HALF_DEF = 200_000;
  localparam int HALF_MAX_W = 64;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] cnt;
    logic [CNT_W_DEF-1:0] half_r;
    logic [CNT_W_DEF-1:0] half_p;
    logic                 pend;
  } ch_state_t;

  // A zero half-period would never wrap; treat it as 1.
  function automatic logic [HALF_MAX_W-1:0] clamp_half(
    input logic [HALF_MAX_W-1:0] h
  );
    return (h == '0) ? HALF_MAX_W'(1) : h;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel (counter, shadow half-period, outputs).
// Ports: clk, rst (sync, active-high), en, sync, wr, wr_half -> pend, clk_out, tick.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_r;
    logic [CNT_W-1:0] half_p;
    logic             pend;
  } st_t;

  st_t  st_q, st_d;
  logic run_q, run_d;
  logic clk_out_q, clk_out_d;
  logic tick_q, tick_d;
  logic restart;
  logic wrap;

  // First enabled edge behaves like a restart so the
  // first rise lands exactly H edges later.
  assign restart = !en || !run_q || sync;
  assign wrap    = st_q.cnt == st_q.half_r - 1'b1;

  always_comb begin
    st_d      = st_q;
    run_d     = en;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (restart) begin
      st_d.cnt  = '0;
      clk_out_d = 1'b0;
      if (st_q.pend) begin
        st_d.half_r = st_q.half_p;
        st_d.pend   = 1'b0;
      end
    end else if (wrap) begin
      st_d.cnt  = '0;
      clk_out_d = ~clk_out_q;
      tick_d    = ~clk_out_q;
      // 1->0 edge closes a full period.
      if (clk_out_q && st_q.pend) begin
        st_d.half_r = st_q.half_p;
        st_d.pend   = 1'b0;
      end
    end else begin
      st_d.cnt = st_q.cnt + 1'b1;
    end
    // Only reachable with pend low, so never
    // collides with an apply above.
    if (wr && !(sync && en)) begin
      st_d.half_p = CNT_W'(clamp_half(HALF_MAX_W'(wr_half)));
      st_d.pend   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q.cnt    <= '0;
      st_q.half_r <= DEF_HALF;
      st_q.half_p <= DEF_HALF;
      st_q.pend   <= 1'b0;
      run_q       <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      st_q      <= st_d;
      run_q     <= run_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pend    = st_q.pend;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH programmable 50% clock/tick dividers with a shadowed
// valid/ready half-period config port. Ports: clk, rst, ch_en, cfg_valid/
// cfg_ready/cfg_ch/cfg_half, clk_out, tick; sync only with CLKDIV_SYNC_EN.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          N_CH         = 4,
  parameter int          CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF,
  localparam int         CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic [N_CH-1:0]  ch_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] wr;
  logic            sync_w;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  // Unmapped channel numbers stay ready and
  // their writes go nowhere.
  always_comb begin
    cfg_ready = 1'b1;
    wr        = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pend[i];
        wr[i]     = cfg_valid & ~pend[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W    (CNT_W),
      .DEF_HALF (CNT_W'(DEFAULT_HALF))
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (ch_en[g]),
      .sync    (sync_w),
      .wr      (wr[g]),
      .wr_half (cfg_half),
      .pend    (pend[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed table-driven bench for clk_div_multi
// plus hand sequences for reload, boundary write, sync and reset.
module tb_clk_div_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ch_en = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_half = '0;
  logic [3:0]  clk_out;
  logic [3:0]  tick;
`ifdef CLKDIV_SYNC_EN
  logic        sync = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clk_div_multi u_dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CLKDIV_SYNC_EN
    .sync      (sync),
`endif
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  typedef struct {
    logic [3:0]  en;
    logic        vld;
    logic [1:0]  ch;
    logic [31:0] half;
    logic        rdy;
    logic [3:0]  clk;
    logic [3:0]  tk;
  } vec_t;

  vec_t tv[23];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] seen;
    logic       hi;
    logic       tk;

    tv[0]  = '{4'b0000, 1'b1, 2'd1, 32'd3, 1'b1, 4'b0000, 4'b0000};
    tv[1]  = '{4'b0010, 1'b0, 2'd1, 32'd0, 1'b0, 4'b0000, 4'b0000};
    tv[2]  = '{4'b0010, 1'b0, 2'd1, 32'd0, 1'b1, 4'b0000, 4'b0000};
    tv[3]  = '{4'b0010, 1'b0, 2'd1, 32'd0, 1'b1, 4'b0000, 4'b0000};
    tv[4]  = '{4'b0010, 1'b0, 2'd1, 32'd0, 1'b1, 4'b0010, 4'b0010};
    tv[5]  = '{4'b0010, 1'b0, 2'd1, 32'd0, 1'b1, 4'b0010, 4'b0000};
    tv[6]  = '{4'b0010, 1'b0, 2'd1, 32'd0, 1'b1, 4'b0010, 4'b0000};
    tv[7]  = '{4'b0010, 1'b0, 2'd1, 32'd0, 1'b1, 4'b0000, 4'b0000};
    tv[8]  = '{4'b0010, 1'b0, 2'd1, 32'd0, 1'b1, 4'b0000, 4'b0000};
    tv[9]  = '{4'b0010, 1'b0, 2'd1, 32'd0, 1'b1, 4'b0000, 4'b0000};
    tv[10] = '{4'b0010, 1'b0, 2'd1, 32'd0, 1'b1, 4'b0010, 4'b0010};
    tv[11] = '{4'b0010, 1'b0, 2'd1, 32'd0, 1'b1, 4'b0010, 4'b0000};
    tv[12] = '{4'b0010, 1'b1, 2'd2, 32'd0, 1'b1, 4'b0010, 4'b0000};
    tv[13] = '{4'b0110, 1'b0, 2'd2, 32'd0, 1'b0, 4'b0000, 4'b0000};
    tv[14] = '{4'b0110, 1'b0, 2'd2, 32'd0, 1'b1, 4'b0100, 4'b0100};
    tv[15] = '{4'b0110, 1'b0, 2'd2, 32'd0, 1'b1, 4'b0000, 4'b0000};
    tv[16] = '{4'b0110, 1'b0, 2'd2, 32'd0, 1'b1, 4'b0110, 4'b0110};
    tv[17] = '{4'b0110, 1'b0, 2'd2, 32'd0, 1'b1, 4'b0010, 4'b0000};
    tv[18] = '{4'b0110, 1'b0, 2'd2, 32'd0, 1'b1, 4'b0110, 4'b0100};
    tv[19] = '{4'b0110, 1'b0, 2'd2, 32'd0, 1'b1, 4'b0000, 4'b0000};
    tv[20] = '{4'b0100, 1'b0, 2'd2, 32'd0, 1'b1, 4'b0100, 4'b0100};
    tv[21] = '{4'b0100, 1'b0, 2'd2, 32'd0, 1'b1, 4'b0000, 4'b0000};
    tv[22] = '{4'b0000, 1'b0, 2'd2, 32'd0, 1'b1, 4'b0000, 4'b0000};

    // Reset state.
    step();
    step();
    chk("rst_clk", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_rdy", 32'(cfg_ready), 32'd1);
    rst = 1'b0;

    // Default H=200000: nothing rises in 1000 cycles.
    ch_en = 4'b0001;
    seen  = '0;
    for (int i = 0; i < 1000; i++) begin
      step();
      seen = seen | clk_out | tick;
    end
    chk("default_quiet", 32'(seen), 32'd0);

    // Table: ch1 H=3, ch2 H=0 -> 1, disable.
    for (int i = 0; i < 23; i++) begin
      ch_en     = tv[i].en;
      cfg_valid = tv[i].vld;
      cfg_ch    = tv[i].ch;
      cfg_half  = tv[i].half;
      #1;
      chk($sformatf("tv%0d_rdy", i), 32'(cfg_ready), 32'(tv[i].rdy));
      step();
      chk($sformatf("tv%0d_clk", i), 32'(clk_out), 32'(tv[i].clk));
      chk($sformatf("tv%0d_tick", i), 32'(tick), 32'(tv[i].tk));
    end
    cfg_valid = 1'b0;

    // ch0 H=4, reload H=5 mid-high, then a
    // boundary-cycle write of H=2.
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_half  = 32'd4;
    #1;
    chk("a_wr4_rdy", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 1'b0;
    ch_en     = 4'b0001;
    step();
    for (int e = 1; e <= 45; e++) begin
      step();
      hi = (e >= 4 && e < 8) || (e >= 13 && e < 18) ||
           (e >= 23 && e < 28) || (e >= 33 && e < 38) ||
           (e >= 40 && e < 42) || (e >= 44);
      tk = (e == 4) || (e == 13) || (e == 23) ||
           (e == 33) || (e == 40) || (e == 44);
      chk($sformatf("a_e%0d_clk", e), 32'(clk_out), 32'({3'b000, hi}));
      chk($sformatf("a_e%0d_tick", e), 32'(tick), 32'({3'b000, tk}));
      if (e == 5) begin
        cfg_valid = 1'b1;
        cfg_half  = 32'd5;
        #1;
        chk("a_wr5_rdy", 32'(cfg_ready), 32'd1);
      end else if (e == 6) begin
        cfg_half = 32'd7;
        #1;
        chk("a_wr7_blocked", 32'(cfg_ready), 32'd0);
      end else if (e == 7) begin
        cfg_valid = 1'b0;
      end else if (e == 8) begin
        chk("a_rdy_back", 32'(cfg_ready), 32'd1);
      end else if (e == 27) begin
        cfg_valid = 1'b1;
        cfg_half  = 32'd2;
        #1;
        chk("b_wr2_rdy", 32'(cfg_ready), 32'd1);
      end else if (e == 28) begin
        cfg_valid = 1'b0;
        #1;
        chk("b_pend_rdy", 32'(cfg_ready), 32'd0);
      end else if (e == 38) begin
        chk("b_rdy_back", 32'(cfg_ready), 32'd1);
      end
    end
    ch_en = 4'b0000;
    step();

`ifdef CLKDIV_SYNC_EN
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_half  = 32'd2;
    step();
    cfg_ch    = 2'd1;
    cfg_half  = 32'd3;
    step();
    cfg_valid = 1'b0;
    ch_en     = 4'b0011;
    for (int i = 0; i < 7; i++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_low", 32'(clk_out), 32'd0);
    chk("sync_tick", 32'(tick), 32'd0);
    for (int e = 1; e <= 6; e++) begin
      step();
      hi = (e >= 2 && e < 4) || (e >= 6);
      tk = (e >= 3 && e < 6);
      chk($sformatf("s_e%0d_clk", e), 32'(clk_out), 32'({2'b00, tk, hi}));
      hi = (e == 2) || (e == 6);
      tk = (e == 3);
      chk($sformatf("s_e%0d_tick", e), 32'(tick), 32'({2'b00, tk, hi}));
    end
`endif

    // Reset mid-run overrides a config write.
    ch_en = 4'b0011;
    seen  = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | clk_out;
    end
    chk("prerst_active", 32'(seen), 32'd3);
    rst       = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_half  = 32'd9;
    step();
    chk("mrst_clk", 32'(clk_out), 32'd0);
    chk("mrst_tick", 32'(tick), 32'd0);
    chk("mrst_rdy", 32'(cfg_ready), 32'd1);
    rst       = 1'b0;
    cfg_valid = 1'b0;
    seen      = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen = seen | clk_out;
    end
    chk("postrst_quiet", 32'(seen), 32'd0);
    chk("postrst_rdy", 32'(cfg_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
